// File: rtl/gate_result_checker.sv
// Response-side checker for the OR/AND/XOR/XNOR gate block. It samples the gate inputs and outputs on a
// valid strobe, counts mismatches and tracks coverage of the four {a,b} input combinations.
module gate_result_checker #(
    parameter int CNT_W       = 8,
    parameter int MIN_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_vld,
    input  logic             a,
    input  logic             b,
    input  logic             cor,
    input  logic             cand,
    input  logic             cxor,
    input  logic             cxnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_flag,
    output logic [3:0]       err_bits,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [3:0]       cov,
    output logic [1:0]       first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_SAMPLES);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [3:0]       mism;
    logic [3:0]       cov_next;
    logic [CNT_W-1:0] smp_next;
    logic [CNT_W-1:0] err_next;

    // start takes priority, so a sample in the same cycle as a restart is dropped
    always_comb begin
        accept   = (state == RUN) && sample_vld && !start;
        mism[0]  = cor   ^ (a | b);
        mism[1]  = cand  ^ (a & b);
        mism[2]  = cxor  ^ (a ^ b);
        mism[3]  = cxnor ^ ~(a ^ b);
        cov_next = cov | (4'b0001 << {a, b});
        smp_next = (smp_cnt == '1) ? smp_cnt : smp_cnt + CNT_W'(1);
        err_next = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // completion is judged on the post-update coverage and count of the accepting edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (start) begin
                    state_next = RUN;
                end else if (accept && (cov_next == 4'hF) && (smp_next >= MIN_CNT)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt    <= '0;
            err_cnt    <= '0;
            err_bits   <= '0;
            cov        <= '0;
            first_fail <= '0;
            err_flag   <= 1'b0;
        end else begin
            err_flag <= 1'b0;
            if (start) begin
                smp_cnt    <= '0;
                err_cnt    <= '0;
                err_bits   <= '0;
                cov        <= '0;
                first_fail <= '0;
            end else if (accept) begin
                smp_cnt  <= smp_next;
                cov      <= cov_next;
                err_bits <= err_bits | mism;
                if (|mism) begin
                    err_cnt  <= err_next;
                    err_flag <= 1'b1;
                    if (err_cnt == '0) first_fail <= {a, b};
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0);

endmodule

// File: tb/tb_gate_result_checker.sv
// Directed bench for gate_result_checker: a default instance plus a CNT_W=3 instance for saturation,
// both fed from the same stimulus.
module tb_gate_result_checker;

    logic clk = 1'b0;
    logic rst;
    logic start, sample_vld, a, b, cor, cand, cxor, cxnor;

    logic       busy, done, pass, err_flag;
    logic [3:0] err_bits, cov;
    logic [7:0] err_cnt, smp_cnt;
    logic [1:0] first_fail;

    logic       s_busy, s_done, s_pass, s_err_flag;
    logic [3:0] s_err_bits, s_cov;
    logic [2:0] s_err_cnt, s_smp_cnt;
    logic [1:0] s_first_fail;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gate_result_checker #(.CNT_W(8), .MIN_SAMPLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sample_vld(sample_vld),
        .a(a), .b(b), .cor(cor), .cand(cand), .cxor(cxor), .cxnor(cxnor),
        .busy(busy), .done(done), .pass(pass), .err_flag(err_flag),
        .err_bits(err_bits), .err_cnt(err_cnt), .smp_cnt(smp_cnt),
        .cov(cov), .first_fail(first_fail)
    );

    gate_result_checker #(.CNT_W(3), .MIN_SAMPLES(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .sample_vld(sample_vld),
        .a(a), .b(b), .cor(cor), .cand(cand), .cxor(cxor), .cxnor(cxnor),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_flag(s_err_flag),
        .err_bits(s_err_bits), .err_cnt(s_err_cnt), .smp_cnt(s_smp_cnt),
        .cov(s_cov), .first_fail(s_first_fail)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // fault bits {xnor,xor,and,or} invert the corresponding gate output
    task automatic applyStimulus(input logic st, input logic vld, input logic ai, input logic bi,
                                 input logic [3:0] fault);
        start      = st;
        sample_vld = vld;
        a          = ai;
        b          = bi;
        cor        = (ai | bi) ^ fault[0];
        cand       = (ai & bi) ^ fault[1];
        cxor       = (ai ^ bi) ^ fault[2];
        cxnor      = ~(ai ^ bi) ^ fault[3];
        @(posedge clk);
        #1;
        start      = 1'b0;
        sample_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; sample_vld = 1'b0;
        a = 1'b0; b = 1'b0; cor = 1'b0; cand = 1'b0; cxor = 1'b0; cxnor = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_smp", smp_cnt, 0);
        checkOutput("rst_cov", cov, 0);
        rst = 1'b0;

        // good sweep
        applyStimulus(1, 0, 0, 0, 4'b0000);
        checkOutput("t2_busy", busy, 1);
        applyStimulus(0, 1, 0, 0, 4'b0000);
        applyStimulus(0, 1, 0, 1, 4'b0000);
        applyStimulus(0, 1, 1, 0, 4'b0000);
        checkOutput("t2_notdone3", done, 0);
        checkOutput("t2_smp3", smp_cnt, 3);
        applyStimulus(0, 1, 1, 1, 4'b0000);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_busy_off", busy, 0);
        checkOutput("t2_pass", pass, 1);
        checkOutput("t2_smp", smp_cnt, 4);
        checkOutput("t2_cov", cov, 4'hF);
        checkOutput("t2_errcnt", err_cnt, 0);
        checkOutput("t2_errflag", err_flag, 0);

        // faulty AND at {a,b}=01
        applyStimulus(1, 0, 0, 0, 4'b0000);
        checkOutput("t3_restart_done", done, 0);
        checkOutput("t3_restart_cov", cov, 0);
        applyStimulus(0, 1, 0, 0, 4'b0000);
        checkOutput("t3_noflag1", err_flag, 0);
        applyStimulus(0, 1, 0, 1, 4'b0010);
        checkOutput("t3_flag", err_flag, 1);
        checkOutput("t3_errcnt2", err_cnt, 1);
        checkOutput("t3_ff", first_fail, 2'b01);
        applyStimulus(0, 1, 1, 0, 4'b0000);
        checkOutput("t3_flag_clear", err_flag, 0);
        applyStimulus(0, 1, 1, 1, 4'b0000);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_pass", pass, 0);
        checkOutput("t3_errbits", err_bits, 4'b0010);
        checkOutput("t3_errcnt", err_cnt, 1);
        checkOutput("t3_ff_hold", first_fail, 2'b01);

        // sample in DONE is ignored
        applyStimulus(0, 1, 1, 1, 4'b1111);
        checkOutput("t5_done_smp", smp_cnt, 4);
        checkOutput("t5_done_err", err_cnt, 1);
        checkOutput("t5_done_bits", err_bits, 4'b0010);
        checkOutput("t5_done_flag", err_flag, 0);
        checkOutput("t5_done_hold", done, 1);

        // coverage gate: six 00 samples before the rest
        applyStimulus(1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 4'b0000);
        applyStimulus(0, 1, 0, 1, 4'b0000);
        applyStimulus(0, 1, 1, 0, 4'b0000);
        checkOutput("t4_notdone8", done, 0);
        checkOutput("t4_cov8", cov, 4'b0111);
        applyStimulus(0, 1, 1, 1, 4'b0000);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_smp", smp_cnt, 9);
        checkOutput("t4_pass", pass, 1);

        // start beats sample_vld in RUN
        applyStimulus(1, 0, 0, 0, 4'b0000);
        applyStimulus(0, 1, 0, 0, 4'b0000);
        checkOutput("t5_smp1", smp_cnt, 1);
        applyStimulus(1, 1, 1, 1, 4'b0001);
        checkOutput("t5_prio_smp", smp_cnt, 0);
        checkOutput("t5_prio_cov", cov, 0);
        checkOutput("t5_prio_err", err_cnt, 0);
        checkOutput("t5_prio_flag", err_flag, 0);
        checkOutput("t5_prio_busy", busy, 1);

        // asynchronous reset mid-RUN with errors recorded
        applyStimulus(0, 1, 0, 0, 4'b0000);
        applyStimulus(0, 1, 1, 0, 4'b0000);
        applyStimulus(0, 1, 0, 1, 4'b0100);
        checkOutput("t1_pre_smp", smp_cnt, 3);
        checkOutput("t1_pre_flag", err_flag, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_smp", smp_cnt, 0);
        checkOutput("t1_err", err_cnt, 0);
        checkOutput("t1_bits", err_bits, 0);
        checkOutput("t1_cov", cov, 0);
        checkOutput("t1_ff", first_fail, 0);
        checkOutput("t1_flag", err_flag, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1, 1, 1, 4'b0001);
        checkOutput("t1_idle_smp", smp_cnt, 0);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_idle_flag", err_flag, 0);

        // saturation on the 3-bit instance
        applyStimulus(1, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 4'b0001);
        checkOutput("t6_s_err", s_err_cnt, 7);
        checkOutput("t6_s_smp", s_smp_cnt, 7);
        checkOutput("t6_s_busy", s_busy, 1);
        checkOutput("t6_s_cov", s_cov, 4'b0001);
        checkOutput("t6_err", err_cnt, 10);
        checkOutput("t6_smp", smp_cnt, 10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
